// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-addressed data memory: byte-addressed
// requests become word reads, read-modify-write for sub-word stores, and extended load data.
module lsu_mem_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_store,
   input  logic [1:0]            i_req_size,
   input  logic                  i_req_unsigned,
   input  logic [ADDR_WIDTH+1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_resp_valid,
   input  logic                  i_resp_ready,
   output logic [DATA_WIDTH-1:0] o_resp_rdata,
   output logic                  o_resp_err,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wd,
   output logic                  o_mem_we,
   input  logic [DATA_WIDTH-1:0] i_mem_rd
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]            r_state;
   logic                  r_store;
   logic [1:0]            r_size;
   logic                  r_unsigned;
   logic [ADDR_WIDTH+1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdbuf;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_err;

   logic                  w_illegal;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [DATA_WIDTH-1:0] w_load;
   logic [DATA_WIDTH-1:0] w_merge;

   assign w_illegal = (i_req_size == 2'b11)
                    | ((i_req_size == 2'b01) & i_req_addr[0])
                    | ((i_req_size == 2'b10) & (i_req_addr[1:0] != 2'b00));

   // Loads extract straight from the memory read port so the result is ready at the READ edge.
   always_comb begin
      w_byte = i_mem_rd[{r_addr[1:0], 3'b000} +: 8];
      w_half = r_addr[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];
      case (r_size)
         2'b00:   w_load = {{(DATA_WIDTH-8){~r_unsigned & w_byte[7]}}, w_byte};
         2'b01:   w_load = {{(DATA_WIDTH-16){~r_unsigned & w_half[15]}}, w_half};
         default: w_load = i_mem_rd;
      endcase
   end

   always_comb begin
      w_merge = r_rdbuf;
      case (r_size)
         2'b00: w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
         2'b01: begin
            if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
            else           w_merge[15:0]  = r_wdata[15:0];
         end
         default: w_merge = r_wdata;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_store    <= 1'b0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdbuf    <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_store    <= i_req_store;
                  r_size     <= i_req_size;
                  r_unsigned <= i_req_unsigned;
                  r_addr     <= i_req_addr;
                  r_wdata    <= i_req_wdata;
                  r_rdata    <= '0;
                  r_err      <= w_illegal;
                  r_state    <= w_illegal ? S_RESP : S_READ;
               end
            end
            S_READ: begin
               r_rdbuf <= i_mem_rd;
               if (!r_store) r_rdata <= w_load;
               r_state <= r_store ? S_WRITE : S_RESP;
            end
            S_WRITE: r_state <= S_RESP;
            S_RESP: begin
               if (i_resp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Memory-side outputs depend on registered state only, never on the request port.
   assign o_req_ready  = (r_state == S_IDLE) & ~i_rst;
   assign o_resp_valid = (r_state == S_RESP);
   assign o_resp_rdata = r_rdata;
   assign o_resp_err   = r_err;
   assign o_mem_addr   = r_addr[ADDR_WIDTH+1:2];
   assign o_mem_wd     = w_merge;
   assign o_mem_we     = (r_state == S_WRITE);

endmodule
